// File: rtl/updown_counter_param.sv
// Parametrised up/down event counter with programmable step, runtime bounds,
// wrap or saturate at the bounds, synchronous load and one-cycle carry/borrow pulses.
module updown_counter_param #(
    parameter int               WIDTH    = 16,
    parameter int               STEP_W   = 4,
    parameter int               SAT_MODE = 0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse,
    input  logic              uphdl,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    output logic [WIDTH-1:0]  count,
    output logic              carry,
    output logic              borrow,
    output logic              at_max,
    output logic              at_min,
    output logic              cfg_err
);

    // One guard bit above the wider operand: the sum never truncates and the
    // top bit of the difference flags a step below zero.
    localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;

    logic [AW-1:0] count_x, step_x, min_x, max_x;
    logic [AW-1:0] sum, diff;
    logic          pulse_ok;

    always_comb begin
        count_x  = {{(AW-WIDTH){1'b0}}, count_q};
        step_x   = {{(AW-STEP_W){1'b0}}, step};
        min_x    = {{(AW-WIDTH){1'b0}}, min_val};
        max_x    = {{(AW-WIDTH){1'b0}}, max_val};
        sum      = count_x + step_x;
        diff     = count_x - step_x;
        cfg_err  = (min_val > max_val);
        pulse_ok = pulse && (step != '0) && !cfg_err;
    end

    // NOTE: every variable gets its hold/idle value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (pulse_ok) begin
            if (uphdl) begin
                if (sum <= max_x) begin
                    count_d = sum[WIDTH-1:0];
                end else begin
                    count_d = (SAT_MODE != 0) ? max_val : min_val;
                    carry_d = 1'b1;
                end
            end else begin
                if (!diff[AW-1] && (diff >= min_x)) begin
                    count_d = diff[WIDTH-1:0];
                end else begin
                    count_d  = (SAT_MODE != 0) ? min_val : max_val;
                    borrow_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= RST_VAL;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign count  = count_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
    assign at_max = (count_q >= max_val);
    assign at_min = (count_q <= min_val);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: a wrap-mode and a saturate-mode
// instance share one stimulus set; expected values are hand-computed.
module tb_updown_counter_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pulse = 1'b0;
    logic        uphdl = 1'b0;
    logic [3:0]  step = 4'd0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] min_val = 16'h0000;
    logic [15:0] max_val = 16'hFFFF;

    logic [15:0] cw, cs;
    logic        carry_w, borrow_w, at_max_w, at_min_w, cfg_err_w;
    logic        carry_s, borrow_s, at_max_s, at_min_s, cfg_err_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(16), .STEP_W(4), .SAT_MODE(0), .RST_VAL(16'h0000)) dut_w (
        .clk(clk), .rst(rst), .pulse(pulse), .uphdl(uphdl), .step(step),
        .load(load), .load_val(load_val), .min_val(min_val), .max_val(max_val),
        .count(cw), .carry(carry_w), .borrow(borrow_w),
        .at_max(at_max_w), .at_min(at_min_w), .cfg_err(cfg_err_w)
    );

    updown_counter_param #(.WIDTH(16), .STEP_W(4), .SAT_MODE(1), .RST_VAL(16'h00A5)) dut_s (
        .clk(clk), .rst(rst), .pulse(pulse), .uphdl(uphdl), .step(step),
        .load(load), .load_val(load_val), .min_val(min_val), .max_val(max_val),
        .count(cs), .carry(carry_s), .borrow(borrow_s),
        .at_max(at_max_s), .at_min(at_min_s), .cfg_err(cfg_err_s)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [15:0] v);
        load_val = v;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic drive_pulse(input logic up, input logic [3:0] st);
        uphdl = up;
        step  = st;
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
    endtask

    task automatic test_reset();
        min_val = 16'h0000;
        max_val = 16'hFFFF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (cw !== 16'h0000) begin n_fail++; $display("FAIL reset_count_w: got %h want %h", cw, 16'h0000); end
        n_checks++; if (cs !== 16'h00A5) begin n_fail++; $display("FAIL reset_count_s: got %h want %h", cs, 16'h00A5); end
        n_checks++; if ({carry_w, borrow_w, carry_s, borrow_s} !== 4'b0000) begin n_fail++; $display("FAIL reset_events: got %b want 0000", {carry_w, borrow_w, carry_s, borrow_s}); end
        n_checks++; if ({at_min_w, at_max_w, cfg_err_w} !== 3'b100) begin n_fail++; $display("FAIL reset_flags_w: got %b want 100", {at_min_w, at_max_w, cfg_err_w}); end
        drive_pulse(1'b1, 4'd0);
        n_checks++; if ({cw, carry_w} !== {16'h0000, 1'b0}) begin n_fail++; $display("FAIL step0_up: got %h/%b want 0000/0", cw, carry_w); end
        drive_pulse(1'b0, 4'd0);
        n_checks++; if ({cw, borrow_w} !== {16'h0000, 1'b0}) begin n_fail++; $display("FAIL step0_down: got %h/%b want 0000/0", cw, borrow_w); end
        n_checks++; if (cs !== 16'h00A5) begin n_fail++; $display("FAIL step0_hold_s: got %h want 00a5", cs); end
    endtask

    task automatic test_wrap_up();
        min_val = 16'd3;
        max_val = 16'd9;
        drive_load(16'd8);
        n_checks++; if ({cw, cs} !== {16'd8, 16'd8}) begin n_fail++; $display("FAIL wup_load: got %h %h want 0008 0008", cw, cs); end
        drive_pulse(1'b1, 4'd2);
        n_checks++; if ({cw, carry_w, borrow_w} !== {16'd3, 2'b10}) begin n_fail++; $display("FAIL wup_wrap: got %h c%b b%b want 0003 c1 b0", cw, carry_w, borrow_w); end
        n_checks++; if ({cs, carry_s} !== {16'd9, 1'b1}) begin n_fail++; $display("FAIL wup_sat: got %h c%b want 0009 c1", cs, carry_s); end
        tick();
        n_checks++; if ({cw, carry_w, carry_s} !== {16'd3, 2'b00}) begin n_fail++; $display("FAIL wup_carry_1cyc: got %h c%b c%b want 0003 c0 c0", cw, carry_w, carry_s); end
        drive_pulse(1'b1, 4'd2);
        n_checks++; if ({cw, carry_w} !== {16'd5, 1'b0}) begin n_fail++; $display("FAIL wup_next: got %h c%b want 0005 c0", cw, carry_w); end
        n_checks++; if ({cs, carry_s, at_max_s} !== {16'd9, 2'b11}) begin n_fail++; $display("FAIL wup_sat_at_max: got %h c%b m%b want 0009 c1 m1", cs, carry_s, at_max_s); end
    endtask

    task automatic test_wrap_down();
        min_val = 16'd3;
        max_val = 16'd9;
        drive_load(16'd4);
        drive_pulse(1'b0, 4'd2);
        n_checks++; if ({cw, borrow_w, carry_w} !== {16'd9, 2'b10}) begin n_fail++; $display("FAIL wdn_wrap: got %h b%b c%b want 0009 b1 c0", cw, borrow_w, carry_w); end
        n_checks++; if ({cs, borrow_s} !== {16'd3, 1'b1}) begin n_fail++; $display("FAIL wdn_sat: got %h b%b want 0003 b1", cs, borrow_s); end
        tick();
        n_checks++; if ({borrow_w, borrow_s} !== 2'b00) begin n_fail++; $display("FAIL wdn_borrow_1cyc: got %b want 00", {borrow_w, borrow_s}); end
        drive_load(16'd7);
        drive_pulse(1'b0, 4'd2);
        n_checks++; if ({cw, borrow_w} !== {16'd5, 1'b0}) begin n_fail++; $display("FAIL wdn_inrange: got %h b%b want 0005 b0", cw, borrow_w); end
        drive_load(16'd0);
        n_checks++; if ({at_min_w, at_max_w} !== 2'b10) begin n_fail++; $display("FAIL wdn_flags_below: got %b want 10", {at_min_w, at_max_w}); end
        drive_pulse(1'b0, 4'd1);
        n_checks++; if ({cw, borrow_w, at_max_w} !== {16'd9, 2'b11}) begin n_fail++; $display("FAIL wdn_underflow: got %h b%b m%b want 0009 b1 m1", cw, borrow_w, at_max_w); end
        n_checks++; if ({cs, borrow_s} !== {16'd3, 1'b1}) begin n_fail++; $display("FAIL wdn_underflow_s: got %h b%b want 0003 b1", cs, borrow_s); end
    endtask

    task automatic test_saturate();
        min_val = 16'h0000;
        max_val = 16'hFFFF;
        drive_load(16'hFFF8);
        drive_pulse(1'b1, 4'd15);
        n_checks++; if ({cs, carry_s} !== {16'hFFFF, 1'b1}) begin n_fail++; $display("FAIL sat_up: got %h c%b want ffff c1", cs, carry_s); end
        n_checks++; if ({cw, carry_w} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL sat_up_wrapinst: got %h c%b want 0000 c1", cw, carry_w); end
        tick();
        drive_pulse(1'b1, 4'd15);
        n_checks++; if ({cs, carry_s} !== {16'hFFFF, 1'b1}) begin n_fail++; $display("FAIL sat_up_again: got %h c%b want ffff c1", cs, carry_s); end
        n_checks++; if ({cw, carry_w} !== {16'h000F, 1'b0}) begin n_fail++; $display("FAIL sat_up_again_w: got %h c%b want 000f c0", cw, carry_w); end
        drive_load(16'd5);
        drive_pulse(1'b0, 4'd15);
        n_checks++; if ({cs, borrow_s, carry_s} !== {16'h0000, 2'b10}) begin n_fail++; $display("FAIL sat_down: got %h b%b c%b want 0000 b1 c0", cs, borrow_s, carry_s); end
        n_checks++; if ({cw, borrow_w} !== {16'hFFFF, 1'b1}) begin n_fail++; $display("FAIL sat_down_w: got %h b%b want ffff b1", cw, borrow_w); end
    endtask

    task automatic test_full_range();
        min_val = 16'h0000;
        max_val = 16'hFFFF;
        drive_load(16'hFFFF);
        drive_pulse(1'b1, 4'd1);
        n_checks++; if ({cw, carry_w} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL full_up: got %h c%b want 0000 c1", cw, carry_w); end
        drive_pulse(1'b1, 4'd1);
        n_checks++; if ({cw, carry_w} !== {16'h0001, 1'b0}) begin n_fail++; $display("FAIL full_up_b2b: got %h c%b want 0001 c0", cw, carry_w); end
        drive_pulse(1'b0, 4'd1);
        drive_pulse(1'b0, 4'd1);
        n_checks++; if ({cw, borrow_w} !== {16'hFFFF, 1'b1}) begin n_fail++; $display("FAIL full_down: got %h b%b want ffff b1", cw, borrow_w); end
    endtask

    task automatic test_priority();
        rst      = 1'b1;
        load     = 1'b1;
        load_val = 16'h1234;
        pulse    = 1'b1;
        uphdl    = 1'b1;
        step     = 4'd1;
        tick();
        n_checks++; if ({cw, cs} !== {16'h0000, 16'h00A5}) begin n_fail++; $display("FAIL prio_rst: got %h %h want 0000 00a5", cw, cs); end
        rst = 1'b0;
        tick();
        n_checks++; if ({cw, cs} !== {16'h1234, 16'h1234}) begin n_fail++; $display("FAIL prio_load: got %h %h want 1234 1234", cw, cs); end
        n_checks++; if ({carry_w, borrow_w, carry_s, borrow_s} !== 4'b0000) begin n_fail++; $display("FAIL prio_load_events: got %b want 0000", {carry_w, borrow_w, carry_s, borrow_s}); end
        load  = 1'b0;
        pulse = 1'b0;
    endtask

    task automatic test_cfg_err();
        min_val = 16'd10;
        max_val = 16'd5;
        #1;
        n_checks++; if ({cfg_err_w, cfg_err_s} !== 2'b11) begin n_fail++; $display("FAIL cfg_err_flag: got %b want 11", {cfg_err_w, cfg_err_s}); end
        drive_pulse(1'b1, 4'd1);
        n_checks++; if ({cw, carry_w, cs, carry_s} !== {16'h1234, 1'b0, 16'h1234, 1'b0}) begin n_fail++; $display("FAIL cfg_err_up_hold: got %h c%b %h c%b want 1234 c0 1234 c0", cw, carry_w, cs, carry_s); end
        drive_pulse(1'b0, 4'd1);
        n_checks++; if ({cw, borrow_w} !== {16'h1234, 1'b0}) begin n_fail++; $display("FAIL cfg_err_down_hold: got %h b%b want 1234 b0", cw, borrow_w); end
        drive_load(16'd7);
        n_checks++; if ({cw, cs} !== {16'd7, 16'd7}) begin n_fail++; $display("FAIL cfg_err_load: got %h %h want 0007 0007", cw, cs); end
        min_val = 16'd0;
        #1;
        n_checks++; if (cfg_err_w !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err_w); end
        drive_pulse(1'b0, 4'd1);
        n_checks++; if ({cw, borrow_w, cs, borrow_s} !== {16'd6, 1'b0, 16'd6, 1'b0}) begin n_fail++; $display("FAIL cfg_err_resume: got %h b%b %h b%b want 0006 b0 0006 b0", cw, borrow_w, cs, borrow_s); end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_full_range();
        test_priority();
        test_cfg_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
